// File: rtl/apb_interconnect.sv
`default_nettype none
// ============================================================================
// Module  : apb_interconnect
// Brief   : Single-master APB router to NUM_SLAVE address regions, with
//           access-phase timeout, sticky timeout flag and completion counters.
// Revision: 1.0 - initial release
// ============================================================================
module apb_interconnect #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    NUM_SLAVE      = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                    REGION_BITS    = 12,
    parameter int                    TIMEOUT_CYCLES = 16,
    parameter int                    CNT_WIDTH      = 16
) (
    input  logic                             S_PCLK,
    input  logic                             S_PRESET,
    input  logic [ADDR_WIDTH-1:0]            S_PADDR,
    input  logic                             S_PSEL,
    input  logic                             S_PENABLE,
    input  logic                             S_PWRITE,
    input  logic [DATA_WIDTH-1:0]            S_PWDATA,
    output logic                             S_PREADY,
    output logic [DATA_WIDTH-1:0]            S_PRDATA,
    output logic                             S_PSLAVEERR,
    output logic [NUM_SLAVE*ADDR_WIDTH-1:0]  M_PADDR,
    output logic [NUM_SLAVE-1:0]             M_PSEL,
    output logic [NUM_SLAVE-1:0]             M_PENABLE,
    output logic [NUM_SLAVE-1:0]             M_PWRITE,
    output logic [NUM_SLAVE*DATA_WIDTH-1:0]  M_PWDATA,
    input  logic [NUM_SLAVE-1:0]             M_PREADY,
    input  logic [NUM_SLAVE*DATA_WIDTH-1:0]  M_PRDATA,
    input  logic [NUM_SLAVE-1:0]             M_PSLAVEERR,
    input  logic                             TO_CLR,
    output logic                             TO_FLAG,
    output logic [CNT_WIDTH-1:0]             XFER_CNT,
    output logic [CNT_WIDTH-1:0]             ERR_CNT
);

    localparam int                c_idx_w    = (NUM_SLAVE > 1) ? $clog2(NUM_SLAVE) : 1;
    localparam int                c_wait_w   = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_wait_w-1:0] c_wait_max = c_wait_w'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ABORT  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [c_idx_w-1:0]      r_sel;
    logic                    r_hit;
    logic [c_wait_w-1:0]     r_wait;
    logic [CNT_WIDTH-1:0]    r_xfer_cnt;
    logic [CNT_WIDTH-1:0]    r_err_cnt;
    logic                    r_to_flag;

    logic [ADDR_WIDTH-1:0]   w_region;
    logic                    w_hit;
    logic [c_idx_w-1:0]      w_idx;
    logic                    w_slv_ready;
    logic                    w_slv_err;
    logic [DATA_WIDTH-1:0]   w_slv_rdata;
    logic [NUM_SLAVE-1:0]    w_psel;
    logic [NUM_SLAVE-1:0]    w_penable;
    logic                    w_ready;
    logic                    w_err;
    logic [DATA_WIDTH-1:0]   w_rdata;
    logic                    w_latch;
    logic                    w_wait_inc;
    logic                    w_to_set;

    // Address decode: region index relative to BASE_ADDR
    always_comb begin
        w_region = (S_PADDR - BASE_ADDR) >> REGION_BITS;
        w_hit    = (S_PADDR >= BASE_ADDR) && (w_region < ADDR_WIDTH'(NUM_SLAVE));
        w_idx    = '0;
        for (int i = 0; i < NUM_SLAVE; i++) begin
            if (w_region == ADDR_WIDTH'(i)) begin
                w_idx = c_idx_w'(i);
            end
        end
    end

    always_comb begin
        w_slv_ready = 1'b0;
        w_slv_err   = 1'b0;
        w_slv_rdata = '0;
        for (int i = 0; i < NUM_SLAVE; i++) begin
            if (r_sel == c_idx_w'(i)) begin
                w_slv_ready = M_PREADY[i];
                w_slv_err   = M_PSLAVEERR[i];
                w_slv_rdata = M_PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign M_PADDR  = {NUM_SLAVE{S_PADDR}};
    assign M_PWRITE = {NUM_SLAVE{S_PWRITE}};
    assign M_PWDATA = {NUM_SLAVE{S_PWDATA}};

    always_ff @(posedge S_PCLK) begin
        if (S_PRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_psel     = '0;
        w_penable  = '0;
        w_ready    = 1'b0;
        w_err      = 1'b0;
        w_rdata    = '0;
        w_latch    = 1'b0;
        w_wait_inc = 1'b0;
        w_to_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (S_PENABLE) begin
                    // Enable without a setup phase: reject in place
                    w_ready = 1'b1;
                    w_err   = 1'b1;
                end else if (S_PSEL) begin
                    w_latch = 1'b1;
                    w_next  = ST_ACCESS;
                    for (int i = 0; i < NUM_SLAVE; i++) begin
                        w_psel[i] = w_hit && (w_idx == c_idx_w'(i));
                    end
                end
            end
            ST_ACCESS: begin
                if (!S_PSEL) begin
                    w_next = ST_IDLE;
                end else if (!r_hit) begin
                    if (S_PENABLE) begin
                        w_ready = 1'b1;
                        w_err   = 1'b1;
                        w_next  = ST_IDLE;
                    end
                end else begin
                    for (int i = 0; i < NUM_SLAVE; i++) begin
                        w_psel[i]    = (r_sel == c_idx_w'(i));
                        w_penable[i] = (r_sel == c_idx_w'(i)) && S_PENABLE;
                    end
                    if (S_PENABLE && w_slv_ready) begin
                        w_ready = 1'b1;
                        w_err   = w_slv_err;
                        w_rdata = w_slv_rdata;
                        w_next  = ST_IDLE;
                    end else if (!w_slv_ready) begin
                        if (r_wait == c_wait_max) begin
                            w_next = ST_ABORT;
                        end else begin
                            w_wait_inc = 1'b1;
                        end
                    end
                end
            end
            ST_ABORT: begin
                w_ready  = 1'b1;
                w_err    = 1'b1;
                w_to_set = 1'b1;
                w_next   = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        // Reset silences every handshake output immediately
        if (S_PRESET) begin
            w_psel    = '0;
            w_penable = '0;
            w_ready   = 1'b0;
            w_err     = 1'b0;
            w_rdata   = '0;
        end
    end

    always_ff @(posedge S_PCLK) begin
        if (S_PRESET) begin
            r_sel      <= '0;
            r_hit      <= 1'b0;
            r_wait     <= '0;
            r_xfer_cnt <= '0;
            r_err_cnt  <= '0;
            r_to_flag  <= 1'b0;
        end else begin
            if (w_latch) begin
                r_sel <= w_idx;
                r_hit <= w_hit;
            end
            if (r_state != ST_ACCESS) begin
                r_wait <= '0;
            end else if (w_wait_inc) begin
                r_wait <= r_wait + c_wait_w'(1);
            end
            if (w_ready && (r_xfer_cnt != '1)) begin
                r_xfer_cnt <= r_xfer_cnt + CNT_WIDTH'(1);
            end
            if (w_ready && w_err && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
            end
            if (w_to_set) begin
                r_to_flag <= 1'b1;
            end else if (TO_CLR) begin
                r_to_flag <= 1'b0;
            end
        end
    end

    assign M_PSEL      = w_psel;
    assign M_PENABLE   = w_penable;
    assign S_PREADY    = w_ready;
    assign S_PSLAVEERR = w_err;
    assign S_PRDATA    = w_rdata;
    assign TO_FLAG     = r_to_flag;
    assign XFER_CNT    = r_xfer_cnt;
    assign ERR_CNT     = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_apb_interconnect.sv
`default_nettype none
// ============================================================================
// Module  : tb_apb_interconnect
// Brief   : Directed and randomized APB transfers against a transaction-level
//           expectation of routing, timeout, flag and counter behaviour.
// Revision: 1.0 - initial release
// ============================================================================
module tb_apb_interconnect;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NS = 4;
    localparam int TO = 16;

    logic             clk = 1'b0;
    logic             s_preset, s_psel, s_penable, s_pwrite, to_clr;
    logic [AW-1:0]    s_paddr;
    logic [DW-1:0]    s_pwdata;
    logic             s_pready, s_pslverr;
    logic [DW-1:0]    s_prdata;
    logic [NS*AW-1:0] m_paddr;
    logic [NS-1:0]    m_psel, m_penable, m_pwrite, m_pready, m_pslverr;
    logic [NS*DW-1:0] m_pwdata, m_prdata;
    logic             to_flag;
    logic [15:0]      xfer_cnt, err_cnt;

    logic             d2_pready, d2_pslverr, d2_to_flag;
    logic [DW-1:0]    d2_prdata;
    logic [NS*AW-1:0] d2_paddr;
    logic [NS-1:0]    d2_psel, d2_penable, d2_pwrite;
    logic [NS*DW-1:0] d2_pwdata;
    logic [1:0]       d2_xfer_cnt, d2_err_cnt;

    int checks = 0;
    int errors = 0;
    int n_xfer = 0;
    int n_err  = 0;
    bit to_exp = 1'b0;

    always #5 clk = ~clk;

    apb_interconnect dut (
        .S_PCLK(clk), .S_PRESET(s_preset), .S_PADDR(s_paddr), .S_PSEL(s_psel),
        .S_PENABLE(s_penable), .S_PWRITE(s_pwrite), .S_PWDATA(s_pwdata),
        .S_PREADY(s_pready), .S_PRDATA(s_prdata), .S_PSLAVEERR(s_pslverr),
        .M_PADDR(m_paddr), .M_PSEL(m_psel), .M_PENABLE(m_penable),
        .M_PWRITE(m_pwrite), .M_PWDATA(m_pwdata), .M_PREADY(m_pready),
        .M_PRDATA(m_prdata), .M_PSLAVEERR(m_pslverr), .TO_CLR(to_clr),
        .TO_FLAG(to_flag), .XFER_CNT(xfer_cnt), .ERR_CNT(err_cnt)
    );

    apb_interconnect #(.CNT_WIDTH(2)) dut2 (
        .S_PCLK(clk), .S_PRESET(s_preset), .S_PADDR(s_paddr), .S_PSEL(s_psel),
        .S_PENABLE(s_penable), .S_PWRITE(s_pwrite), .S_PWDATA(s_pwdata),
        .S_PREADY(d2_pready), .S_PRDATA(d2_prdata), .S_PSLAVEERR(d2_pslverr),
        .M_PADDR(d2_paddr), .M_PSEL(d2_psel), .M_PENABLE(d2_penable),
        .M_PWRITE(d2_pwrite), .M_PWDATA(d2_pwdata), .M_PREADY(m_pready),
        .M_PRDATA(m_prdata), .M_PSLAVEERR(m_pslverr), .TO_CLR(to_clr),
        .TO_FLAG(d2_to_flag), .XFER_CNT(d2_xfer_cnt), .ERR_CNT(d2_err_cnt)
    );

    function automatic int sat(input int n, input int w);
        int lim;
        lim = (1 << w) - 1;
        return (n > lim) ? lim : n;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rand_slaves();
        m_pready  = NS'($urandom);
        m_pslverr = NS'($urandom);
        for (int i = 0; i < NS; i++) m_prdata[i*DW +: DW] = $urandom;
    endtask

    // Checks one cycle mid-period, then advances the expectation to the next edge
    task automatic step(input logic [NS-1:0] e_psel, input logic [NS-1:0] e_pen,
                        input logic e_rdy, input logic e_err,
                        input logic [DW-1:0] e_rdata, input bit abort_c);
        #3;
        chk("M_PSEL",      m_psel,    e_psel);
        chk("M_PENABLE",   m_penable, e_pen);
        chk("S_PREADY",    s_pready,  e_rdy);
        chk("S_PSLAVEERR", s_pslverr, e_err);
        chk("S_PRDATA",    s_prdata,  e_rdata);
        chk("XFER_CNT",    xfer_cnt,  sat(n_xfer, 16));
        chk("ERR_CNT",     err_cnt,   sat(n_err, 16));
        chk("TO_FLAG",     to_flag,   to_exp);
        chk("XFER_CNT_w2", d2_xfer_cnt, sat(n_xfer, 2));
        chk("ERR_CNT_w2",  d2_err_cnt,  sat(n_err, 2));
        chk("M_PADDR",     m_paddr,   {NS{s_paddr}});
        chk("M_PWDATA",    m_pwdata,  {NS{s_pwdata}});
        chk("M_PWRITE",    m_pwrite,  {NS{s_pwrite}});
        if (s_preset) begin
            n_xfer = 0;
            n_err  = 0;
            to_exp = 1'b0;
        end else begin
            if (e_rdy) begin
                n_xfer++;
                if (e_err) n_err++;
            end
            if (abort_c) to_exp = 1'b1;
            else if (to_clr) to_exp = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s_psel    = 1'b0;
        s_penable = 1'b0;
        rand_slaves();
        step('0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    // One full transfer: region = addr / 4096, mapped when region < NS; target
    // slave becomes ready in access cycle nwait+1, timeout after TO stalled cycles
    task automatic do_xfer(input logic [AW-1:0] addr, input bit wr, input int nwait,
                           input bit force_ok);
        logic [NS-1:0] oh;
        bit            mapped;
        int            idx;
        bit            fin;
        mapped = (addr >> 12) < NS;
        idx    = mapped ? int'(addr >> 12) : 0;
        oh     = '0;
        if (mapped) oh[idx] = 1'b1;
        s_psel    = 1'b1;
        s_penable = 1'b0;
        s_paddr   = addr;
        s_pwrite  = wr;
        s_pwdata  = $urandom;
        rand_slaves();
        step(oh, '0, 1'b0, 1'b0, '0, 1'b0);
        s_penable = 1'b1;
        fin = 1'b0;
        for (int k = 1; k <= TO + 1 && !fin; k++) begin
            rand_slaves();
            if (mapped) begin
                m_pready[idx] = (k > nwait) && (k <= TO);
                if (force_ok) m_pslverr[idx] = 1'b0;
            end
            if (!mapped) begin
                step('0, '0, 1'b1, 1'b1, '0, 1'b0);
                fin = 1'b1;
            end else if (k > TO) begin
                step('0, '0, 1'b1, 1'b1, '0, 1'b1);
                fin = 1'b1;
            end else if (k > nwait) begin
                step(oh, oh, 1'b1, m_pslverr[idx], m_prdata[idx*DW +: DW], 1'b0);
                fin = 1'b1;
            end else begin
                step(oh, oh, 1'b0, 1'b0, '0, 1'b0);
            end
        end
        s_psel    = 1'b0;
        s_penable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        s_preset  = 1'b1;
        s_psel    = 1'b1;
        s_penable = 1'b1;
        s_pwrite  = 1'b0;
        s_paddr   = 32'h0000_1000;
        s_pwdata  = '0;
        to_clr    = 1'b0;
        m_pready  = '1;
        m_pslverr = '1;
        for (int i = 0; i < NS; i++) m_prdata[i*DW +: DW] = $urandom;
        @(posedge clk);
        #1;
        // Reset held with an active-looking master: everything stays quiet
        step('0, '0, 1'b0, 1'b0, '0, 1'b0);
        step('0, '0, 1'b0, 1'b0, '0, 1'b0);
        s_preset = 1'b0;
        idle();

        // Write to slave 1, two wait states
        do_xfer(32'h0000_1004, 1'b1, 2, 1'b1);
        idle();
        // Unmapped read
        do_xfer(32'h0000_4000, 1'b0, 0, 1'b0);
        idle();
        // Back-to-back reads of slave 0 then slave 3
        do_xfer(32'h0000_0010, 1'b0, 1, 1'b1);
        do_xfer(32'h0000_3FFC, 1'b0, 0, 1'b1);
        idle();

        // Enable without setup in IDLE, then a normal transfer still works
        s_psel    = 1'b1;
        s_penable = 1'b1;
        s_paddr   = 32'h0000_2008;
        rand_slaves();
        step('0, '0, 1'b1, 1'b1, '0, 1'b0);
        do_xfer(32'h0000_2008, 1'b1, 0, 1'b0);

        // Master drops PSEL mid-access: abandoned without completion
        s_psel    = 1'b1;
        s_penable = 1'b0;
        s_paddr   = 32'h0000_1100;
        rand_slaves();
        step(4'b0010, '0, 1'b0, 1'b0, '0, 1'b0);
        s_penable = 1'b1;
        rand_slaves();
        m_pready[1] = 1'b0;
        step(4'b0010, 4'b0010, 1'b0, 1'b0, '0, 1'b0);
        idle();
        do_xfer(32'h0000_1200, 1'b0, 1, 1'b0);

        // Stalled slave 2: abort in access cycle 17, sticky flag until TO_CLR
        do_xfer(32'h0000_2000, 1'b0, 40, 1'b0);
        idle();
        idle();
        to_clr = 1'b1;
        idle();
        to_clr = 1'b0;
        idle();
        // Boundary: ready in the last allowed cycle completes normally
        do_xfer(32'h0000_3010, 1'b1, TO - 1, 1'b0);
        idle();
        // Abort while TO_CLR is held: set wins
        to_clr = 1'b1;
        do_xfer(32'h0000_3000, 1'b0, TO, 1'b0);
        idle();
        to_clr = 1'b0;
        idle();

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            logic [AW-1:0] a;
            int            w;
            a = AW'($urandom_range(0, 5)) << 12;
            a = a | (AW'($urandom_range(0, 1023)) << 2);
            if ($urandom_range(0, 9) == 0) a = $urandom;
            w = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 18) : $urandom_range(0, 3);
            do_xfer(a, 1'($urandom), w, 1'b0);
            if ($urandom_range(0, 1) == 1) idle();
        end
        idle();

        // Reset in the 2nd access cycle abandons the transfer
        s_psel    = 1'b1;
        s_penable = 1'b0;
        s_paddr   = 32'h0000_2040;
        rand_slaves();
        step(4'b0100, '0, 1'b0, 1'b0, '0, 1'b0);
        s_penable = 1'b1;
        rand_slaves();
        m_pready[2] = 1'b0;
        step(4'b0100, 4'b0100, 1'b0, 1'b0, '0, 1'b0);
        s_preset = 1'b1;
        m_pready = '1;
        step('0, '0, 1'b0, 1'b0, '0, 1'b0);
        s_preset = 1'b0;
        idle();

        // Five error completions: 2-bit counter saturates at 3
        for (int n = 0; n < 5; n++) begin
            do_xfer(32'h0000_4000 + 32'(n * 4), 1'b0, 0, 1'b0);
        end
        idle();
        chk("ERR_CNT_w2_sat", d2_err_cnt, 2'd3);
        chk("ERR_CNT_final", err_cnt, 16'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_interconnect.md
APB_INTERCONNECT -- requirements
Module: apb_interconnect

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 32, address width.
- NUM_SLAVE, 4, slave ports, 1..16.
- BASE_ADDR, 0, start of slave 0 region.
- REGION_BITS, 12, log2 of region size per slave.
- TIMEOUT_CYCLES, 16, access-phase wait limit, >=2.
- CNT_WIDTH, 16, status counter width.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- S_PCLK, in, 1, the single clock.
- S_PRESET, in, 1, reset; synchronous, active-high.
- S_PADDR, in, ADDR_WIDTH, master address.
- S_PSEL, in, 1, master select.
- S_PENABLE, in, 1, master enable.
- S_PWRITE, in, 1, master direction.
- S_PWDATA, in, DATA_WIDTH, master write data.
- S_PREADY, out, 1, ready to master.
- S_PRDATA, out, DATA_WIDTH, read data to master.
- S_PSLAVEERR, out, 1, error to master.
- M_PADDR, out, NUM_SLAVE x ADDR_WIDTH, per-slave address.
- M_PSEL, out, NUM_SLAVE, per-slave select.
- M_PENABLE, out, NUM_SLAVE, per-slave enable.
- M_PWRITE, out, NUM_SLAVE, per-slave direction.
- M_PWDATA, out, NUM_SLAVE x DATA_WIDTH, per-slave write data.
- M_PREADY, in, NUM_SLAVE, per-slave ready.
- M_PRDATA, in, NUM_SLAVE x DATA_WIDTH, per-slave read data.
- M_PSLAVEERR, in, NUM_SLAVE, per-slave error.
- TO_CLR, in, 1, clears TO_FLAG.
- TO_FLAG, out, 1, sticky timeout flag.
- XFER_CNT, out, CNT_WIDTH, completed transfers.
- ERR_CNT, out, CNT_WIDTH, error completions.

Function
REQ-003 Decode SHALL be combinational: hit = (S_PADDR >= BASE_ADDR) and idx < NUM_SLAVE, where idx = (S_PADDR - BASE_ADDR) >> REGION_BITS.
REQ-004 Broadcast SHALL apply: M_PADDR, M_PWRITE, M_PWDATA driven from master inputs on all ports.
REQ-005 FSM states SHALL be IDLE, ACCESS, ABORT.
REQ-006 IDLE SHALL handle setup and violations:
- On S_PSEL=1, S_PENABLE=0: latch idx and hit into sel_q/hit_q; go to ACCESS.
- During that setup cycle: M_PSEL[idx]=1 if hit; all M_PENABLE=0.
REQ-007 In ACCESS, port sel_q SHALL get M_PSEL=S_PSEL and M_PENABLE=S_PENABLE; all other ports 0.
REQ-008 Mapped ACCESS response SHALL be S_PREADY=M_PREADY[sel_q], S_PSLAVEERR=M_PSLAVEERR[sel_q], S_PRDATA=M_PRDATA[sel_q], with no added latency.
REQ-009 Unmapped ACCESS (hit_q=0) SHALL complete in the first access cycle: S_PREADY=1, S_PSLAVEERR=1, S_PRDATA=0, all M_PSEL=0.
REQ-010 ACCESS SHALL return to IDLE on completion (S_PSEL & S_PENABLE & S_PREADY); back-to-back setup in the next cycle is accepted.
REQ-011 Wait counter SHALL time out a stalled slave:
- Counts ACCESS cycles with M_PREADY[sel_q]=0; cleared on entering ACCESS.
- At TIMEOUT_CYCLES-1, the next state is ABORT.
REQ-012 ABORT SHALL last exactly one cycle, then IDLE:
- M_PSEL=0, M_PENABLE=0 on all ports.
- S_PREADY=1, S_PSLAVEERR=1, S_PRDATA=0.
- TO_FLAG set.
REQ-013 TO_FLAG SHALL be sticky, cleared by TO_CLR; a simultaneous set takes priority over clear.
REQ-014 XFER_CNT SHALL increment on each completion; ERR_CNT SHALL increment on each completion with S_PSLAVEERR=1. Both saturate at all-ones.
REQ-015 Outside completion cycles, S_PREADY, S_PSLAVEERR and S_PRDATA SHALL be 0.
REQ-016 S_PENABLE=1 in IDLE without a prior setup (protocol violation) SHALL get an unmapped-style error completion that same cycle; counters update; state stays IDLE.
REQ-017 S_PSEL dropping in ACCESS before completion SHALL return the FSM to IDLE with no completion counted.

Reset
REQ-018 While S_PRESET=1 at the S_PCLK edge, the block SHALL reset to:
- FSM IDLE; sel_q, hit_q, wait counter, XFER_CNT, ERR_CNT = 0; TO_FLAG = 0.
REQ-019 While S_PRESET is held, the block SHALL drive M_PSEL=0, M_PENABLE=0, S_PREADY=0, S_PSLAVEERR=0, S_PRDATA=0.
REQ-020 Reset asserted mid-ACCESS or in ABORT SHALL abandon the transfer without counting it.

Verification
REQ-021 Write to 0x1004, slave 1 ready after 2 waits:
- Only M_PSEL[1] asserted.
- Completion in 3rd access cycle.
- XFER_CNT=1, ERR_CNT=0.
REQ-022 Read 0x4000 with NUM_SLAVE=4 (unmapped):
- No M_PSEL asserted.
- S_PREADY=1, S_PSLAVEERR=1, S_PRDATA=0 in the first access cycle.
- ERR_CNT=1.
REQ-023 Slave 2 holds PREADY=0 at default TIMEOUT_CYCLES=16:
- ABORT in access cycle 17 with S_PSLAVEERR=1.
- TO_FLAG=1 until TO_CLR pulse.
REQ-024 Back-to-back reads of slave 0 then slave 3, no idle cycle:
- Correct M_PRDATA routed per transfer.
- XFER_CNT=2.
REQ-025 Reset mid-ACCESS, then counter stress:
- Reset asserted in 2nd access cycle: next cycle all outputs 0, counters 0.
- CNT_WIDTH=2, 5 error completions: ERR_CNT saturates at 3.
